csr_spmv_engine: RTL
====================

# csr_spmv_engine

Parametrised CSR sparse-matrix × dense-vector engine; the successor to the fixed-size HHT `control` block. It walks a row-pointer array, a column-index array, a matrix-value array and a dense vector through two read ports. It computes one dot product per row and streams each result out over a valid/ready handshake. Row count, data width and accumulator width are run-time or compile-time configurable, replacing the fixed 16×16 walk. The block also adds back-pressure, empty-row handling and malformed-pointer detection.

## Interface
- `DATA_W`, 32, width of every memory word (row pointers, column indices, values).
- `ADDR_W`, 32, memory address width.
- `ACC_W`, 64, accumulator / result width (≥ DATA_W).
- `ROW_W`, 16, width of row count and row index.
- `Clk` in 1: single clock, all state updates on rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `start` in 1: launch a run; sampled only in IDLE.
- `num_rows` in ROW_W: rows to process; sampled with `start`.
- `row_base`, `col_base`, `mat_base`, `vec_base` in ADDR_W each: array base addresses; sampled with `start`.
- `addr1` out ADDR_W: port-1 read address (row pointers, column indices).
- `dataIn1` in DATA_W: port-1 read data, combinational from `addr1`.
- `addr2` out ADDR_W: port-2 read address (matrix values, vector values).
- `dataIn2` in DATA_W: port-2 read data, combinational from `addr2`.
- `y_valid` out 1, `y_ready` in 1: result handshake.
- `y_data` out ACC_W: row dot product.
- `y_row` out ROW_W: row index of `y_data`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `err` out 1: sticky, set on a malformed row pointer; cleared by `start` or `Rst`.

## Operation
- States: IDLE, PTR0, PTR, NZ_A, NZ_B, EMIT, DONE.
- IDLE:
  - `start`=1 latches bases and `num_rows`, clears `err`.
  - If `num_rows`=0, go to DONE; otherwise go to PTR0.
- PTR0: `addr1`=row_base. Capture `rp_lo`=dataIn1 and set r=0.
- PTR: `addr1`=row_base+r+1. Capture `rp_hi`=dataIn1, set k=rp_lo, clear acc.
  - If rp_hi>rp_lo, go to NZ_A.
  - If rp_hi=rp_lo, go to EMIT (empty row, result 0).
  - If rp_hi<rp_lo, set `err`, treat the row as empty, go to EMIT.
- NZ_A: `addr1`=col_base+k and `addr2`=mat_base+k. Capture col and val. Go to NZ_B.
- NZ_B: `addr2`=vec_base+col. Update acc += val×dataIn2, then k++.
  - If k+1==rp_hi, go to EMIT; otherwise go to NZ_A.
- EMIT:
  - `y_valid`=1, `y_data`=acc, `y_row`=r, all held stable until accepted.
  - On `y_valid`&&`y_ready`: set rp_lo=rp_hi, r++.
  - If r+1==num_rows, go to DONE; otherwise go to PTR.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - Unsigned. Product is 2·DATA_W bits, zero-extended or truncated to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
- Address arithmetic wraps modulo 2^ADDR_W.
- `start` outside IDLE is ignored. Base and count inputs may change freely after the start cycle.
- `addr1`/`addr2` in states that do not use them hold their last value. Reading is side-effect free.

## Timing
- Reset values: all outputs 0, state IDLE, `y_data`=0, `y_row`=0.
- `Rst` mid-run aborts immediately to IDLE, drops `y_valid` with no handshake, and emits no `done`.
- `busy` is high in every state except IDLE. `busy` is low in the `done` cycle.
- Let E0 be the edge sampling `start`. Then:
  - PTR0 occupies cycle E0→E1.
  - PTR of row 0 occupies E1→E2.
  - A row with n nonzeros uses 2n cycles.
  - `y_valid` rises at edge E(2+2n).
- Steady state per row with `y_ready` held 1: 1 + 2n + 1 cycles.
- Back-pressure: EMIT holds any number of cycles. No addresses advance and outputs stay stable.
- `done` is asserted the cycle after the final accepting edge.
- `num_rows`=0: `done` is high during cycle E1→E2 and `y_valid` never rises.

## Test plan
- Basic run. Stimulus:
  - row_ptr={0,2,2}, col={1,3}, val={5,7}, x={9,10,11,4}, num_rows=2, y_ready=1.
  - Required: y(0)=78 with y_valid at E6, then y(1)=0, then a `done` pulse; err=0.
- 16×16 run with row_ptr {0,7,12,18,19,27,32,36,41,48,52,55,59,64,69,73,78}:
  - Required: 16 results in row order matching a software CSR reference, with per-row cycle counts of 2+2n.
- Back-pressure: hold y_ready=0 for 5 cycles on row 0.
  - Required: y_data/y_row stable, address ports frozen, and the total run length grows by exactly 5.
- Malformed row: row_ptr={0,3,1}.
  - Required: row 1 emits 0, err=1 stays high through done, and the next `start` clears it.
- Edge cases:
  - num_rows=0: done exactly 1 cycle after PTR0 is skipped (E1→E2), with y_valid=0.
  - `start` pulsed while busy: ignored.
  - Accumulator overflow with ACC_W=32, val=x=0xFFFF_FFFF: y_data=1.
- `Rst` asserted during NZ_B of row 3.
  - Required: next cycle all outputs 0, state IDLE, no `done`.
  - A new `start` then runs correctly from row 0.

Source files
------------

// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine
// Computes y = A*x for a CSR-encoded sparse matrix A and a dense vector x.
// Port 1 fetches row pointers and column indices; port 2 fetches matrix
// values and vector entries. Each row's dot product goes out on a
// valid/ready handshake. All outputs are registered. Each address is
// loaded on the clock edge that enters the state which uses it, so the
// combinational read data is valid for the whole state.
module csr_spmv_engine #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int ACC_W  = 64,
   parameter int ROW_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic [ADDR_W-1:0] row_base,
   input  logic [ADDR_W-1:0] col_base,
   input  logic [ADDR_W-1:0] mat_base,
   input  logic [ADDR_W-1:0] vec_base,
   output logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] dataIn1,
   output logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] dataIn2,
   output logic              y_valid,
   input  logic              y_ready,
   output logic [ACC_W-1:0]  y_data,
   output logic [ROW_W-1:0]  y_row,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PROD_W = 2 * DATA_W;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PTR0 = 3'd1;
   localparam logic [2:0] PTR  = 3'd2;
   localparam logic [2:0] NZ_A = 3'd3;
   localparam logic [2:0] NZ_B = 3'd4;
   localparam logic [2:0] EMIT = 3'd5;
   localparam logic [2:0] DONE = 3'd6;

   logic [2:0]        state_r;
   logic [ROW_W-1:0]  num_rows_r;
   logic [ROW_W-1:0]  r_r;
   logic [ADDR_W-1:0] row_base_r;
   logic [ADDR_W-1:0] col_base_r;
   logic [ADDR_W-1:0] mat_base_r;
   logic [ADDR_W-1:0] vec_base_r;
   logic [DATA_W-1:0] rp_lo_r;
   logic [DATA_W-1:0] rp_hi_r;
   logic [DATA_W-1:0] k_r;
   logic [DATA_W-1:0] val_r;
   logic [ACC_W-1:0]  acc_r;

   logic [PROD_W-1:0] prod_s;
   logic [ACC_W-1:0]  acc_sum_s;
   logic [DATA_W-1:0] k_next_s;
   logic [ROW_W-1:0]  r_next_s;

   // Element address: base + index, wrapping modulo 2^ADDR_W
   function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [DATA_W-1:0] idx);
      return base + ADDR_W'(idx);
   endfunction

   // Address of row_ptr[row+1], the upper bound of the given row
   function automatic logic [ADDR_W-1:0] row_end_addr(input logic [ADDR_W-1:0] base,
                                                       input logic [ROW_W-1:0]  row);
      return base + ADDR_W'(row) + ADDR_W'(1'b1);
   endfunction

   // Multiply-accumulate and index increments used by the sequencer
   always_comb begin
      prod_s    = PROD_W'(val_r) * PROD_W'(dataIn2);
      acc_sum_s = acc_r + ACC_W'(prod_s);
      k_next_s  = k_r + DATA_W'(1'b1);
      r_next_s  = r_r + ROW_W'(1'b1);
   end

   // Row-walk sequencer with registered outputs and address ports
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r    <= IDLE;
         num_rows_r <= '0;
         r_r        <= '0;
         row_base_r <= '0;
         col_base_r <= '0;
         mat_base_r <= '0;
         vec_base_r <= '0;
         rp_lo_r    <= '0;
         rp_hi_r    <= '0;
         k_r        <= '0;
         val_r      <= '0;
         acc_r      <= '0;
         addr1      <= '0;
         addr2      <= '0;
         y_valid    <= 1'b0;
         y_data     <= '0;
         y_row      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  num_rows_r <= num_rows;
                  row_base_r <= row_base;
                  col_base_r <= col_base;
                  mat_base_r <= mat_base;
                  vec_base_r <= vec_base;
                  r_r        <= '0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  state_r    <= PTR0;
                  // An empty run still spends one slot here but fetches nothing
                  if (num_rows != '0) begin
                     addr1 <= row_base;
                  end else begin
                     addr1 <= addr1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            PTR0: begin
               if (num_rows_r == '0) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end else begin
                  rp_lo_r <= dataIn1;
                  r_r     <= '0;
                  addr1   <= row_end_addr(row_base_r, ROW_W'(1'b0));
                  state_r <= PTR;
               end
            end
            PTR: begin
               rp_hi_r <= dataIn1;
               k_r     <= rp_lo_r;
               acc_r   <= '0;
               if (dataIn1 > rp_lo_r) begin
                  addr1   <= word_addr(col_base_r, rp_lo_r);
                  addr2   <= word_addr(mat_base_r, rp_lo_r);
                  state_r <= NZ_A;
               end else begin
                  // Equal pointers: empty row. Decreasing pointers: flag and treat as empty.
                  if (dataIn1 < rp_lo_r) begin
                     err <= 1'b1;
                  end else begin
                     err <= err;
                  end
                  y_valid <= 1'b1;
                  y_data  <= '0;
                  y_row   <= r_r;
                  state_r <= EMIT;
               end
            end
            NZ_A: begin
               // The vector address is formed straight from the fetched column index
               val_r   <= dataIn2;
               addr2   <= word_addr(vec_base_r, dataIn1);
               state_r <= NZ_B;
            end
            NZ_B: begin
               acc_r <= acc_sum_s;
               k_r   <= k_next_s;
               if (k_next_s == rp_hi_r) begin
                  y_valid <= 1'b1;
                  y_data  <= acc_sum_s;
                  y_row   <= r_r;
                  state_r <= EMIT;
               end else begin
                  addr1   <= word_addr(col_base_r, k_next_s);
                  addr2   <= word_addr(mat_base_r, k_next_s);
                  state_r <= NZ_A;
               end
            end
            EMIT: begin
               if (y_ready) begin
                  y_valid <= 1'b0;
                  rp_lo_r <= rp_hi_r;
                  r_r     <= r_next_s;
                  if (r_next_s == num_rows_r) begin
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_r <= DONE;
                  end else begin
                     addr1   <= row_end_addr(row_base_r, r_next_s);
                     state_r <= PTR;
                  end
               end else begin
                  state_r <= EMIT;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               y_valid <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
